// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: default widths, occupancy
// encoding and the bit positions inside the control field.
package pipe_pkg;

  localparam int CTRL_LEN_DEF = 9;
  localparam int DATA_LEN_DEF = 108;
  localparam int CNT_LEN_DEF  = 16;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int CTRL_WB_EN       = 0;
  localparam int CTRL_MEM_R       = 1;
  localparam int CTRL_MEM_W       = 2;
  localparam int CTRL_B           = 3;
  localparam int CTRL_S           = 4;
  localparam int CTRL_EXE_CMD_LSB = 5;

  // The FSM state value doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } occ_state_e;

  typedef struct packed {
    logic head_load;
    logic head_from_skid;
    logic skid_load;
    logic clear;
  } slot_ctl_t;

endpackage

// File: rtl/stage_slot.sv
// One {ctrl,data} storage slot. Clear wins over load so a flushed slot
// always reads as a zeroed bubble.
module stage_slot #(
  parameter int CTRL_LEN = 9,
  parameter int DATA_LEN = 108
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clear,
  input  logic [CTRL_LEN-1:0] d_ctrl,
  input  logic [DATA_LEN-1:0] d_data,
  output logic [CTRL_LEN-1:0] q_ctrl,
  output logic [DATA_LEN-1:0] q_data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (clear) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, freeze and flush.
// in_ready depends only on the occupancy register and freeze, never on in_valid.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_LEN = CTRL_LEN_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int CNT_LEN  = CNT_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_LEN-1:0] in_ctrl,
  input  logic [DATA_LEN-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_LEN-1:0] out_ctrl,
  output logic [DATA_LEN-1:0] out_data,
  input  logic                freeze,
  input  logic                flush,
  output logic [1:0]          occupancy,
  output logic [CNT_LEN-1:0]  flush_drop_cnt
);

  // Handshake: a transfer happens on a cycle where valid and ready are both
  // high at the rising edge. push = in_valid & in_ready; pop = out_valid &
  // out_ready & ~freeze. Flush overrides both but does not alter in_ready.

  occ_state_e state_q, state_d;
  slot_ctl_t  ctl;
  logic       push, pop;

  logic [CTRL_LEN-1:0] head_ctrl, skid_ctrl, head_d_ctrl;
  logic [DATA_LEN-1:0] head_data, skid_data, head_d_data;

  assign occupancy = state_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL) & ~freeze;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    if (flush) begin
      state_d   = ST_EMPTY;
      ctl.clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d       = ST_ONE;
            ctl.head_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            ctl.head_load = 1'b1;
          end else if (push) begin
            state_d       = ST_FULL;
            ctl.skid_load = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid entry can advance.
          if (pop) begin
            state_d            = ST_ONE;
            ctl.head_load      = 1'b1;
            ctl.head_from_skid = 1'b1;
          end
        end
        default: begin
          state_d   = ST_EMPTY;
          ctl.clear = 1'b1;
        end
      endcase
    end
  end

  assign head_d_ctrl = ctl.head_from_skid ? skid_ctrl : in_ctrl;
  assign head_d_data = ctl.head_from_skid ? skid_data : in_data;

  stage_slot #(.CTRL_LEN(CTRL_LEN), .DATA_LEN(DATA_LEN)) u_head (
    .clk    (clk),
    .rst    (rst),
    .load   (ctl.head_load),
    .clear  (ctl.clear),
    .d_ctrl (head_d_ctrl),
    .d_data (head_d_data),
    .q_ctrl (head_ctrl),
    .q_data (head_data)
  );

  stage_slot #(.CTRL_LEN(CTRL_LEN), .DATA_LEN(DATA_LEN)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (ctl.skid_load),
    .clear  (ctl.clear),
    .d_ctrl (in_ctrl),
    .d_data (in_data),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

  // Bubbles must never carry live control bits downstream.
  assign out_ctrl = out_valid ? head_ctrl : '0;
  assign out_data = head_data;

  localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

  logic [1:0]         drop_n;
  logic [CNT_LEN+1:0] cnt_sum;
  logic [CNT_LEN-1:0] cnt_q;

  // A push accepted in the flush cycle is discarded too, so it counts.
  assign drop_n  = occupancy + {1'b0, push};
  assign cnt_sum = (CNT_LEN + 2)'(cnt_q) + (CNT_LEN + 2)'(drop_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (flush) begin
      if (cnt_sum > (CNT_LEN + 2)'(CNT_MAX)) cnt_q <= CNT_MAX;
      else                                   cnt_q <= cnt_sum[CNT_LEN-1:0];
    end
  end

  assign flush_drop_cnt = cnt_q;

endmodule
